pdp8_kl8e: RTL and testbench

Console teletype interface for the pdp8 CPU: keyboard (device 03) and printer (device 04), KL8E-compatible. It sits directly downstream of the CPU's IOT execution. It decodes IOT microinstructions, returns skip and AC-transfer controls in the same cycle, serialises printer characters onto an 8N1 line, and deserialises keyboard characters from one. Its flags drive the CPU interrupt request.

---
 rtl/pdp8_kl8e.sv | 240 ++++++++++++++++++++++++
 tb/tb_pdp8_kl8e.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pdp8_kl8e.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : pdp8_kl8e
//  Purpose  : KL8E-compatible console teletype for the PDP-8. Keyboard is
//             device 03 and printer is device 04. IOT decode is combinational.
//             The printer serialises onto an 8N1 txd line and the keyboard
//             deserialises an 8N1 rxd line.
//  Revision : 1.0 - initial release
// ============================================================================
module pdp8_kl8e #(
   parameter int BAUD_DIV = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       iot,
   input  logic [5:0] io_select,
   input  logic [2:0] io_op,
   input  logic [7:0] io_data_in,
   output logic [7:0] io_data_out,
   output logic       io_ac_clear,
   output logic       io_ac_or,
   output logic       io_skip,
   output logic       interrupt_req,
   input  logic       rxd,
   output logic       txd
);

   localparam int              CW       = $clog2(BAUD_DIV);
   localparam logic [CW-1:0]   CNT_LAST = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0]   CNT_HALF = CW'(BAUD_DIV / 2 - 1);
   localparam logic [5:0]      DEV_KBD  = 6'o03;
   localparam logic [5:0]      DEV_TTY  = 6'o04;

   localparam logic [1:0]      S_IDLE   = 2'd0;
   localparam logic [1:0]      S_START  = 2'd1;
   localparam logic [1:0]      S_DATA   = 2'd2;
   localparam logic [1:0]      S_STOP   = 2'd3;

   // Flags and buffers
   logic       kbd_flag;
   logic       tty_flag;
   logic [7:0] kbd_buf;
   logic [7:0] tx_buf;

   // IOT decode strobes
   logic kbd_sel;
   logic tty_sel;
   logic kbd_flag_clr;
   logic tty_flag_set_iot;
   logic tty_flag_clr;
   logic tx_load;

   // Transmitter
   logic [1:0]    tx_state;
   logic [1:0]    tx_next;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic          tx_cnt_last;
   logic          tx_done;

   // Receiver
   logic          rx_s1;
   logic          rx_s2;
   logic          rx_prev;
   logic          rx_fall;
   logic [1:0]    rx_state;
   logic [1:0]    rx_next;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift;
   logic          rx_cnt_last;
   logic          rx_sample;
   logic          rx_wrap;
   logic          rx_done;

   // IOT decode: CPU-facing controls are purely combinational
   always_comb begin
      kbd_sel          = iot && (io_select == DEV_KBD);
      tty_sel          = iot && (io_select == DEV_TTY);
      io_skip          = (kbd_sel && (io_op == 3'o1) && kbd_flag) ||
                         (tty_sel && (io_op == 3'o1) && tty_flag);
      io_ac_clear      = kbd_sel && ((io_op == 3'o2) || (io_op == 3'o6));
      io_ac_or         = kbd_sel && ((io_op == 3'o4) || (io_op == 3'o6));
      io_data_out      = io_ac_or ? kbd_buf : 8'h00;
      kbd_flag_clr     = kbd_sel && ((io_op == 3'o0) || (io_op == 3'o2) || (io_op == 3'o6));
      tty_flag_set_iot = tty_sel && (io_op == 3'o0);
      tty_flag_clr     = tty_sel && ((io_op == 3'o2) || (io_op == 3'o6));
      tx_load          = tty_sel && ((io_op == 3'o4) || (io_op == 3'o6));
   end

   assign interrupt_req = kbd_flag | tty_flag;

   // Flag registers: a hardware set wins over a coincident IOT clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kbd_flag <= 1'b0;
         tty_flag <= 1'b0;
      end else begin
         if (rx_done)
            kbd_flag <= 1'b1;
         else if (kbd_flag_clr)
            kbd_flag <= 1'b0;

         if (tx_done || tty_flag_set_iot)
            tty_flag <= 1'b1;
         else if (tty_flag_clr)
            tty_flag <= 1'b0;
      end
   end

   // ---------------------------------------------------------------- TX ----

   // TX state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tx_state <= S_IDLE;
      else
         tx_state <= tx_next;
   end

   // TX next-state: a load while busy is ignored here, so the frame is undisturbed
   always_comb begin
      tx_next = tx_state;
      case (tx_state)
         S_IDLE:  if (tx_load)                          tx_next = S_START;
         S_START: if (tx_cnt_last)                      tx_next = S_DATA;
         S_DATA:  if (tx_cnt_last && (tx_bit == 3'd7))  tx_next = S_STOP;
         S_STOP:  if (tx_cnt_last)                      tx_next = S_IDLE;
         default:                                       tx_next = S_IDLE;
      endcase
   end

   // TX outputs: line level follows the state directly so reset forces idle-high at once
   always_comb begin
      tx_cnt_last = (tx_cnt == CNT_LAST);
      tx_done     = (tx_state == S_STOP) && tx_cnt_last;
      case (tx_state)
         S_START: txd = 1'b0;
         S_DATA:  txd = tx_buf[tx_bit];
         default: txd = 1'b1;
      endcase
   end

   // TX datapath: bit timer, bit index and character buffer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_cnt <= '0;
         tx_bit <= 3'd0;
         tx_buf <= 8'h00;
      end else begin
         if ((tx_state == S_IDLE) || tx_cnt_last)
            tx_cnt <= '0;
         else
            tx_cnt <= tx_cnt + 1'b1;

         if (tx_state != S_DATA)
            tx_bit <= 3'd0;
         else if (tx_cnt_last)
            tx_bit <= tx_bit + 3'd1;

         if ((tx_state == S_IDLE) && tx_load)
            tx_buf <= io_data_in;
      end
   end

   // ---------------------------------------------------------------- RX ----

   // RX synchroniser plus one delayed copy for falling-edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rxd;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   assign rx_fall = rx_prev & ~rx_s2;

   // RX state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rx_state <= S_IDLE;
      else
         rx_state <= rx_next;
   end

   // RX next-state: a high start sample is treated as a glitch
   always_comb begin
      rx_next = rx_state;
      case (rx_state)
         S_IDLE:  if (rx_fall)                          rx_next = S_START;
         S_START: if (rx_cnt == CNT_HALF)               rx_next = rx_s2 ? S_IDLE : S_DATA;
         S_DATA:  if (rx_cnt_last && (rx_bit == 3'd7))  rx_next = S_STOP;
         S_STOP:  if (rx_cnt_last)                      rx_next = S_IDLE;
         default:                                       rx_next = S_IDLE;
      endcase
   end

   // RX outputs: sample strobes; after the half-bit start sample, every full bit lands mid-bit
   always_comb begin
      rx_cnt_last = (rx_cnt == CNT_LAST);
      rx_sample   = (rx_state == S_DATA) && rx_cnt_last;
      rx_done     = (rx_state == S_STOP) && rx_cnt_last && rx_s2;
      rx_wrap     = ((rx_state == S_START) && (rx_cnt == CNT_HALF)) ||
                    (((rx_state == S_DATA) || (rx_state == S_STOP)) && rx_cnt_last);
   end

   // RX datapath: bit timer, shift register and keyboard buffer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_cnt   <= '0;
         rx_bit   <= 3'd0;
         rx_shift <= 8'h00;
         kbd_buf  <= 8'h00;
      end else begin
         if ((rx_state == S_IDLE) || rx_wrap)
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + 1'b1;

         if (rx_state != S_DATA)
            rx_bit <= 3'd0;
         else if (rx_cnt_last)
            rx_bit <= rx_bit + 3'd1;

         if (rx_sample)
            rx_shift <= {rx_s2, rx_shift[7:1]};

         if (rx_done)
            kbd_buf <= rx_shift;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pdp8_kl8e.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_pdp8_kl8e
//  Purpose  : Self-checking bench for the KL8E console teletype
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pdp8_kl8e;

   localparam int B = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       iot = 1'b0;
   logic [5:0] io_select = 6'o00;
   logic [2:0] io_op = 3'o0;
   logic [7:0] io_data_in = 8'h00;
   logic [7:0] io_data_out;
   logic       io_ac_clear;
   logic       io_ac_or;
   logic       io_skip;
   logic       interrupt_req;
   logic       rxd = 1'b1;
   logic       txd;

   pdp8_kl8e #(.BAUD_DIV(B)) dut (
      .clk           (clk),
      .reset         (reset),
      .iot           (iot),
      .io_select     (io_select),
      .io_op         (io_op),
      .io_data_in    (io_data_in),
      .io_data_out   (io_data_out),
      .io_ac_clear   (io_ac_clear),
      .io_ac_or      (io_ac_or),
      .io_skip       (io_skip),
      .interrupt_req (interrupt_req),
      .rxd           (rxd),
      .txd           (txd)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic       cap_skip, cap_clr, cap_or;
   logic [7:0] cap_data;
   int         meas = -1;

   typedef struct {
      logic       iot;
      logic [5:0] sel;
      logic [2:0] op;
      logic       skip;
      logic       clr;
      logic       orr;
      logic [7:0] data;
   } vec_t;

   vec_t vecs[16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One IOT cycle: driven at a negedge, outputs captured, dropped at the next negedge
   task automatic iot_op(input logic [5:0] sel, input logic [2:0] op, input logic [7:0] d);
      @(negedge clk);
      io_select  = sel;
      io_op      = op;
      io_data_in = d;
      iot        = 1'b1;
      #1;
      cap_skip = io_skip;
      cap_clr  = io_ac_clear;
      cap_or   = io_ac_or;
      cap_data = io_data_out;
      @(negedge clk);
      iot = 1'b0;
   endtask

   // 8N1 character on rxd; start bit begins at the first negedge
   task automatic send_rx(input logic [7:0] ch, input logic stopb);
      @(negedge clk);
      rxd = 1'b0;
      repeat (B) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = ch[i];
         repeat (B) @(negedge clk);
      end
      rxd = stopb;
      repeat (B) @(negedge clk);
      rxd = 1'b1;
   endtask

   // Checks a TX frame started by an IOT that just returned (k=0 is the negedge after edge E).
   // Optionally fires a TPC of inj_ch at negedge inj_k.
   task automatic check_frame(input string tag, input logic [7:0] ch, input int inj_k, input logic [7:0] inj_ch);
      logic [9:0] fr;
      fr = {1'b1, ch, 1'b0};
      for (int k = 0; k < 10 * B; k++) begin
         if (k > 0) @(negedge clk);
         if (k == inj_k) begin
            io_select = 6'o04; io_op = 3'o4; io_data_in = inj_ch; iot = 1'b1;
         end
         if (k == inj_k + 1) iot = 1'b0;
         if (k == 0)     check({tag, "_txd_fall_at_E"}, txd, 1'b0);
         if (k == B - 1) check({tag, "_start_last_clk"}, txd, 1'b0);
         if ((k % B) == B / 2)
            check($sformatf("%s_bit%0d", tag, k / B), txd, fr[k / B]);
         if (k == 10 * B - 1) check({tag, "_irq_before_end"}, interrupt_req, 1'b0);
      end
      @(negedge clk);
      check({tag, "_irq_after_end"}, interrupt_req, 1'b1);
   endtask

   initial begin
      // Decode table, applied with tty_flag=1, kbd_flag=0, kbd_buf=A5
      vecs[0]  = '{1'b0, 6'o03, 3'o6, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[1]  = '{1'b1, 6'o03, 3'o0, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[2]  = '{1'b1, 6'o03, 3'o1, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[3]  = '{1'b1, 6'o03, 3'o2, 1'b0, 1'b1, 1'b0, 8'h00};
      vecs[4]  = '{1'b1, 6'o03, 3'o3, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[5]  = '{1'b1, 6'o03, 3'o4, 1'b0, 1'b0, 1'b1, 8'hA5};
      vecs[6]  = '{1'b1, 6'o03, 3'o5, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[7]  = '{1'b1, 6'o03, 3'o6, 1'b0, 1'b1, 1'b1, 8'hA5};
      vecs[8]  = '{1'b1, 6'o03, 3'o7, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[9]  = '{1'b1, 6'o04, 3'o1, 1'b1, 1'b0, 1'b0, 8'h00};
      vecs[10] = '{1'b0, 6'o04, 3'o1, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[11] = '{1'b1, 6'o04, 3'o6, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[12] = '{1'b1, 6'o04, 3'o3, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[13] = '{1'b1, 6'o05, 3'o1, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[14] = '{1'b1, 6'o13, 3'o6, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[15] = '{1'b1, 6'o43, 3'o4, 1'b0, 1'b0, 1'b0, 8'h00};

      // ---- reset state
      repeat (3) @(negedge clk);
      check("rst_txd", txd, 1'b1);
      check("rst_irq", interrupt_req, 1'b0);
      check("rst_skip", io_skip, 1'b0);
      check("rst_clr", io_ac_clear, 1'b0);
      check("rst_or", io_ac_or, 1'b0);
      check("rst_data", io_data_out, 8'h00);
      reset = 1'b0;

      // ---- print 0x41 with TLS
      iot_op(6'o04, 3'o6, 8'h41);
      check_frame("print", 8'h41, -10, 8'h00);
      iot_op(6'o04, 3'o1, 8'h00);
      check("print_tsf_skip", cap_skip, 1'b1);
      iot_op(6'o04, 3'o2, 8'h00);

      // ---- keyboard 0xA5, with flag latency measured from the rxd fall
      fork
         send_rx(8'hA5, 1'b1);
         begin
            @(negedge clk);
            for (int k = 1; k < 10 * B + 5; k++) begin
               @(negedge clk);
               if (interrupt_req && meas < 0) meas = k;
            end
         end
      join
      check("kbd_flag_latency_in_window", (meas >= 2 + 9 * B + B / 2 - 1) && (meas <= 2 + 9 * B + B / 2 + 1), 1'b1);
      if (meas < 0) meas = 2 + 9 * B + B / 2;
      iot_op(6'o03, 3'o1, 8'h00);
      check("kbd_ksf_skip", cap_skip, 1'b1);
      iot_op(6'o03, 3'o6, 8'h00);
      check("kbd_krb_clr", cap_clr, 1'b1);
      check("kbd_krb_or", cap_or, 1'b1);
      check("kbd_krb_data", cap_data, 8'hA5);
      iot_op(6'o03, 3'o1, 8'h00);
      check("kbd_ksf_after_krb", cap_skip, 1'b0);

      // ---- decode table
      iot_op(6'o04, 3'o0, 8'h00);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         iot = vecs[i].iot; io_select = vecs[i].sel; io_op = vecs[i].op;
         #1;
         check($sformatf("vec%0d_skip", i), io_skip, vecs[i].skip);
         check($sformatf("vec%0d_clr", i), io_ac_clear, vecs[i].clr);
         check($sformatf("vec%0d_or", i), io_ac_or, vecs[i].orr);
         check($sformatf("vec%0d_data", i), io_data_out, vecs[i].data);
         iot = 1'b0;
      end
      iot_op(6'o04, 3'o2, 8'h00);
      check("tcf_clears_irq", interrupt_req, 1'b0);

      // ---- 6-clock glitch
      @(negedge clk);
      rxd = 1'b0;
      repeat (6) @(negedge clk);
      rxd = 1'b1;
      repeat (12 * B) @(negedge clk);
      iot_op(6'o03, 3'o1, 8'h00);
      check("glitch_no_flag", cap_skip, 1'b0);

      // ---- framing error
      send_rx(8'h3C, 1'b0);
      repeat (2 * B) @(negedge clk);
      iot_op(6'o03, 3'o1, 8'h00);
      check("framing_no_flag", cap_skip, 1'b0);
      iot_op(6'o03, 3'o4, 8'h00);
      check("framing_buf_kept", cap_data, 8'hA5);

      // ---- overrun: two characters without a read
      send_rx(8'h12, 1'b1);
      repeat (B) @(negedge clk);
      send_rx(8'h34, 1'b1);
      repeat (B) @(negedge clk);
      iot_op(6'o03, 3'o1, 8'h00);
      check("overrun_flag", cap_skip, 1'b1);
      iot_op(6'o03, 3'o4, 8'h00);
      check("overrun_buf", cap_data, 8'h34);
      iot_op(6'o03, 3'o6, 8'h00);

      // ---- KCC on the exact cycle RX completes
      fork
         send_rx(8'h5A, 1'b1);
         begin
            @(negedge clk);
            repeat (meas - 2) @(negedge clk);
            iot_op(6'o03, 3'o2, 8'h00);
            check("kcc_coincident_clr", cap_clr, 1'b1);
         end
      join
      iot_op(6'o03, 3'o1, 8'h00);
      check("kcc_coincident_flag_wins", cap_skip, 1'b1);
      iot_op(6'o03, 3'o6, 8'h00);
      check("kcc_coincident_buf", cap_data, 8'h5A);

      // ---- TCF on the exact cycle TX completes
      iot_op(6'o04, 3'o6, 8'h41);
      repeat (10 * B - 2) @(negedge clk);
      iot_op(6'o04, 3'o2, 8'h00);
      iot_op(6'o04, 3'o1, 8'h00);
      check("tcf_coincident_flag_wins", cap_skip, 1'b1);
      iot_op(6'o04, 3'o2, 8'h00);

      // ---- busy: TPC 0x55 during a 0x41 frame
      iot_op(6'o04, 3'o4, 8'h41);
      check_frame("busy", 8'h41, 40, 8'h55);
      iot_op(6'o04, 3'o2, 8'h00);
      begin
         int lows;
         lows = 0;
         for (int k = 0; k < 12 * B; k++) begin
            @(negedge clk);
            if (txd !== 1'b1) lows++;
         end
         check("busy_no_second_frame", lows, 0);
      end
      check("busy_single_flag", interrupt_req, 1'b0);

      // ---- reset mid-frame
      iot_op(6'o04, 3'o0, 8'h00);
      send_rx(8'h77, 1'b1);
      repeat (B) @(negedge clk);
      iot_op(6'o04, 3'o4, 8'h00);
      repeat (3 * B) @(negedge clk);
      check("midframe_txd_low", txd, 1'b0);
      check("midframe_irq_high", interrupt_req, 1'b1);
      #1 reset = 1'b1;
      #1;
      check("async_rst_txd", txd, 1'b1);
      check("async_rst_irq", interrupt_req, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      iot_op(6'o04, 3'o1, 8'h00);
      check("post_rst_tsf", cap_skip, 1'b0);
      iot_op(6'o03, 3'o1, 8'h00);
      check("post_rst_ksf", cap_skip, 1'b0);
      iot_op(6'o03, 3'o4, 8'h00);
      check("post_rst_buf", cap_data, 8'h00);
      repeat (2 * B) @(negedge clk);
      check("post_rst_txd_idle", txd, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
